alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a width-bit product (low width bits of op_a*op_b) by sequencing the shared combinational ALU through shift-and-add iterations.
- Sits between the control unit and the ALU. While busy it owns the ALU operand/select bus; a start/done handshake lets the core stall on multiply instructions.
- The low width bits are identical for signed and unsigned operands, so one block serves both.

Parameters:
- width, 32, operand, result and ALU bus width (>=2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  width  multiplicand, captured when start is accepted.
- op_b  input  width  multiplier, captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  width  product low bits; held until the next accepted start.
- alu_sel  output  3  ALU select; 3'b010 (add) in RUN, 3'b000 otherwise.
- alu_op1  output  width  ALU operand 1; accumulator P in RUN, 0 otherwise.
- alu_op2  output  width  ALU operand 2; shifted multiplicand M in RUN, 0 otherwise.
- alu_result  input  width  combinational ALU output.

Behaviour:
- All state updates on rising clk. reset_n is synchronous and active-low; reset has priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, result=0, P=M=Q=0, cnt=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and op_b!=0: M<=op_a, Q<=op_b, P<=0, cnt<=0, next RUN.
  - start=1 and op_b==0: P<=0, next DONE, so done is high on cycle t+1.
  - start=0: stay in IDLE.
- RUN, per cycle:
  - ALU bus driven combinationally from registers: alu_sel=3'b010, alu_op1=P, alu_op2=M.
  - If Q[0]=1, P<=alu_result; otherwise P holds.
  - M<=M<<1 (MSB discarded), Q<=Q>>1 (zero fill), cnt<=cnt+1.
  - If Q>>1 == 0 or cnt==width-1, next DONE; otherwise stay in RUN.
- RUN-cycle count: N = (index of highest set bit of op_b) + 1, so 1<=N<=width. The start accepted on the edge ending cycle t gives RUN in cycles t+1..t+N and done=1 in cycle t+N+1.
- DONE: done=1, busy=1, result=P, and result is registered on entry so it is valid in the same cycle as done. Next state is IDLE unconditionally.
- result keeps its value in IDLE until the next accepted start's DONE cycle; it is not cleared when start is accepted.
- Arithmetic is modulo 2^width; overflow bits are discarded silently and no flag is produced.
- start while busy (RUN or DONE) is ignored, not queued. start in the same cycle as DONE is also ignored; it is accepted only in IDLE.
- Reset mid-operation: on the next edge everything returns to reset values, no done is produced, and the ALU bus returns to 0/3'b000 that cycle.
- busy is a registered output: 1 in RUN and DONE, 0 in IDLE.
- done never stays high for two consecutive cycles.
- op_a and op_b may change freely after acceptance without affecting the operation.

Test Plan:
- Basic: op_a=3, op_b=2, start at cycle 0 -> RUN cycles 1-2 with alu_sel=010; done=1 and result=6 in cycle 3; busy=0 in cycle 4.
- Zero multiplier: op_a=0x1234, op_b=0 -> done in cycle 1, result=0, and no RUN cycle ever drives alu_sel=010.
- Full length with wrap: op_a=op_b=0xFFFFFFFF -> exactly 32 RUN cycles, done in cycle 33, result=0x00000001. Also op_a=0x80000000, op_b=2 -> result=0 (modulo).
- Signed equivalence: op_a=-3 (0xFFFFFFFD), op_b=5 -> done in cycle 4, result=0xFFFFFFF1 (-15).
- Ignored start: start op_a=7, op_b=0x100. Re-pulse start with op_a=1, op_b=1 at cycles 3 and 10 (DONE) -> done in cycle 10 with result=0x700, no second done. A start at cycle 11 is accepted.
- Reset mid-op: op_a=5, op_b=0xF0, drive reset_n=0 in cycle 4 -> cycle 5 shows busy=0, done=0, result=0, alu_sel=000, alu_op1=alu_op2=0. A new start afterwards completes normally.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply sequencer: drives the shared ALU with add operations
// until the low width bits of op_a*op_b are accumulated, then pulses done.
module alu_mul_sequencer #(
    parameter int width = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [width-1:0] op_a,
    input  logic [width-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result,
    output logic [2:0]       alu_sel,
    output logic [width-1:0] alu_op1,
    output logic [width-1:0] alu_op2,
    input  logic [width-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b000;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [width-1:0] result_q, result_d;
    logic [width-1:0] p_q, p_d;
    logic [width-1:0] m_q, m_d;
    logic [width-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [width-1:0] p_step;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            p_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            p_q      <= p_d;
            m_q      <= m_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
        end
    end

    // Accumulator value after this RUN cycle; also what result captures on exit.
    assign p_step = q_q[0] ? alu_result : p_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        p_d      = p_q;
        m_d      = m_q;
        q_d      = q_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d = '0;
                    if (op_b != '0) begin
                        m_d     = op_a;
                        q_d     = op_b;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        result_d = '0;
                        state_d  = DONE;
                    end
                end
            end
            RUN: begin
                p_d   = p_step;
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (((q_q >> 1) == '0) || (cnt_q == CNT_W'(width - 1))) begin
                    result_d = p_step;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_comb begin
        alu_sel = ALU_NONE;
        alu_op1 = '0;
        alu_op2 = '0;
        if (state_q == RUN) begin
            alu_sel = ALU_ADD;
            alu_op1 = p_q;
            alu_op2 = m_q;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized and directed bench for alu_mul_sequencer, checked against a
// plain-arithmetic model of product value and RUN-cycle latency.
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_op1;
    logic [W-1:0] alu_op2;
    logic [W-1:0] alu_result;

    int assertCount = 0;
    int failCount   = 0;

    alu_mul_sequencer #(.width(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_sel    (alu_sel),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small stand-in for the shared ALU; only add matters to the sequencer.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_result = alu_op1 & alu_op2;
            3'b001:  alu_result = alu_op1 | alu_op2;
            3'b010:  alu_result = alu_op1 + alu_op2;
            3'b110:  alu_result = alu_op1 - alu_op2;
            default: alu_result = '0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int refRunCycles(input logic [W-1:0] b);
        int n = 0;
        for (int k = 0; k < W; k++) if (b[k]) n = k + 1;
        return n;
    endfunction

    // Launch one multiply, follow it to done and compare against the model.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] expProd;
        int           expN;
        int           cycles;
        int           runSeen;
        expProd = a * b;
        expN    = refRunCycles(b);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        tick();
        start   = 1'b0;
        op_a    = $urandom;
        op_b    = $urandom;
        cycles  = 1;
        runSeen = 0;
        if (expN > 0) begin
            checkOutput("first_run_op1", alu_op1, '0);
            checkOutput("first_run_op2", alu_op2, a);
        end
        while (!done && cycles < W + 8) begin
            if (alu_sel == 3'b010) runSeen++;
            tick();
            cycles++;
        end
        checkOutput("done_seen", {31'b0, done}, 32'd1);
        checkOutput("latency", cycles, expN + 1);
        checkOutput("run_cycles", runSeen, expN);
        checkOutput("result", result, expProd);
        checkOutput("busy_in_done", {31'b0, busy}, 32'd1);
        tick();
        checkOutput("done_pulse", {31'b0, done}, 32'd0);
        checkOutput("busy_idle", {31'b0, busy}, 32'd0);
        checkOutput("result_held", result, expProd);
        checkOutput("alu_sel_idle", {29'b0, alu_sel}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op_a    = '0;
        op_b    = '0;
        tick();
        tick();
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_result", result, '0);
        checkOutput("rst_alu_sel", {29'b0, alu_sel}, 32'd0);
        checkOutput("rst_alu_op1", alu_op1, '0);
        reset_n = 1'b1;
        tick();

        applyStimulus(32'd3, 32'd2);
        applyStimulus(32'h1234, 32'd0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(32'h8000_0000, 32'd2);
        applyStimulus(32'hFFFF_FFFD, 32'd5);
        applyStimulus(32'd1, 32'h8000_0000);

        // Starts during RUN and DONE must be dropped; the one in IDLE is taken.
        @(negedge clk);
        start = 1'b1;
        op_a  = 32'd7;
        op_b  = 32'h100;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        op_a  = 32'd1;
        op_b  = 32'd1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        checkOutput("ign_done", {31'b0, done}, 32'd1);
        checkOutput("ign_result", result, 32'h700);
        start = 1'b1;
        op_a  = 32'd1;
        op_b  = 32'd1;
        tick();
        checkOutput("ign_no_second_done", {31'b0, done}, 32'd0);
        checkOutput("ign_idle_busy", {31'b0, busy}, 32'd0);
        op_a = 32'd2;
        op_b = 32'd3;
        tick();
        start = 1'b0;
        checkOutput("acc_busy", {31'b0, busy}, 32'd1);
        checkOutput("acc_alu_sel", {29'b0, alu_sel}, 32'd2);
        tick();
        tick();
        checkOutput("acc_done", {31'b0, done}, 32'd1);
        checkOutput("acc_result", result, 32'd6);
        tick();

        // Synchronous reset in the middle of a RUN sequence.
        @(negedge clk);
        start = 1'b1;
        op_a  = 32'd5;
        op_b  = 32'hF0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        checkOutput("midrst_result", result, '0);
        checkOutput("midrst_alu_sel", {29'b0, alu_sel}, 32'd0);
        checkOutput("midrst_alu_op1", alu_op1, '0);
        checkOutput("midrst_alu_op2", alu_op2, '0);
        reset_n = 1'b1;
        applyStimulus(32'd9, 32'd11);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 7 == 0) b = '0;
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
